// File: rtl/cache_mem_pkg.sv
// Shared constants for the I/D cache memory-port arbiter.
package cache_mem_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Requester identifiers
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/cache_mem_arb_pick.sv
// Combinational winner selection between the I and D cache requesters.
module cache_mem_arb_pick
    import cache_mem_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // A lone requester always wins; a tie goes to D (fixed) or the side not served last (round-robin)
    always_comb begin
        grant_valid = req_i | req_d;
        grant_id    = REQ_I;
        if (req_i && req_d) begin
            grant_id = (FIXED_PRIO != 0) ? REQ_D : ~last_grant;
        end else if (req_d) begin
            grant_id = REQ_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between the instruction and data caches.
//
// state   | meaning
// IDLE    | no transaction; arbitrate among current requests
// BUSY    | command registered on mem_*; waiting for mem_ready
// RELEASE | winner's ready pulse is high; requests ignored for this cycle
module cache_mem_arbiter
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    logic [1:0] state;
    logic       last_grant;
    logic       owner;
    logic       grant_valid;
    logic       grant_id;

    cache_mem_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .req_i       (i_mem_read | i_mem_write),
        .req_d       (d_mem_read | d_mem_write),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Arbitration FSM plus the registered memory command and per-side return path
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state       <= ST_IDLE;
            last_grant  <= REQ_D;
            owner       <= REQ_I;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            i_mem_rdata <= '0;
            i_mem_ready <= 1'b0;
            d_mem_rdata <= '0;
            d_mem_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        state      <= ST_BUSY;
                        // write wins when a side asserts both read and write
                        if (grant_id == REQ_D) begin
                            mem_write <= d_mem_write;
                            mem_read  <= d_mem_read & ~d_mem_write;
                            mem_addr  <= d_mem_addr;
                            mem_wdata <= d_mem_wdata;
                        end else begin
                            mem_write <= i_mem_write;
                            mem_read  <= i_mem_read & ~i_mem_write;
                            mem_addr  <= i_mem_addr;
                            mem_wdata <= i_mem_wdata;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= ST_RELEASE;
                        if (owner == REQ_D) begin
                            d_mem_rdata <= mem_rdata;
                            d_mem_ready <= 1'b1;
                        end else begin
                            i_mem_rdata <= mem_rdata;
                            i_mem_ready <= 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    i_mem_ready <= 1'b0;
                    d_mem_ready <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single 128-bit memory port between an instruction cache (I side) and a data cache (D side).
- Each side presents the same mem_read/mem_write/mem_addr/mem_wdata handshake that a cache normally drives into memory.
- The arbiter picks one side, registers its command, drives memory until mem_ready, then returns data and a one-cycle ready pulse to the winner.

Parameters:
- ADDR_W, 28, block address width.
- DATA_W, 128, line width.
- FIXED_PRIO, 0, selects arbitration: 0 = round-robin between I and D; 1 = D side has strict priority.

Ports:
- clk  in  1  system clock, rising edge.
- proc_reset_n  in  1  reset, asynchronous, active-low.
- i_mem_read  in  1  I-side read request.
- i_mem_write  in  1  I-side write request.
- i_mem_addr  in  ADDR_W  I-side block address.
- i_mem_wdata  in  DATA_W  I-side write line.
- i_mem_rdata  out  DATA_W  I-side returned line.
- i_mem_ready  out  1  I-side completion pulse.
- d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready: same as the I side, for the D side.
- mem_read  out  1  to memory.
- mem_write  out  1  to memory.
- mem_addr  out  ADDR_W  to memory.
- mem_wdata  out  DATA_W  to memory.
- mem_rdata  in  DATA_W  from memory.
- mem_ready  in  1  from memory.

Behaviour:
- Reset (asynchronous, proc_reset_n=0):
  - State IDLE; all outputs 0.
  - last_grant = D, so I wins the first tie.
  - Reset during BUSY abandons the memory transaction; no ready pulse is issued.
- Request: req_x = x_mem_read | x_mem_write.
  - If both read and write are asserted on one side, the command is a write; the read is ignored.
- State IDLE:
  - With no requests, stay in IDLE.
  - Otherwise choose a winner:
    - Only one side requesting: that side wins.
    - Both requesting, FIXED_PRIO=0: the side not equal to last_grant wins.
    - Both requesting, FIXED_PRIO=1: D wins.
  - At that clock edge: register addr, wdata and op into the mem_* outputs, set last_grant, go to BUSY.
  - mem_read or mem_write is first visible one cycle after the request is sampled.
- State BUSY:
  - mem_* outputs are held constant regardless of requester inputs; a requester dropping its request mid-transaction has no effect.
  - On the edge where mem_ready=1:
    - Clear mem_read and mem_write; mem_addr and mem_wdata hold.
    - Register mem_rdata into the winner's x_mem_rdata.
    - Set the winner's x_mem_ready=1.
    - Go to RELEASE.
  - For writes, x_mem_rdata is still updated with whatever mem_rdata carries.
- State RELEASE (exactly one cycle):
  - x_mem_ready is high during this cycle.
  - Requests are ignored, so a stale request from the winner is not re-granted.
  - On the next edge: clear x_mem_ready, go to IDLE.
- Ready and data rules:
  - x_mem_ready is high for exactly one cycle per granted transaction.
  - The loser's ready stays 0; its rdata holds its last value.
- mem_ready sampled in IDLE or RELEASE is ignored.
- Minimum turnaround with a zero-wait memory is 3 cycles per transaction (IDLE→BUSY→RELEASE).
- No starvation under FIXED_PRIO=0: with both sides continuously requesting, grants alternate I,D,I,D.
- Under FIXED_PRIO=1, I is served only in IDLE cycles where D is not requesting.

Decomposition:
- Shared package cache_mem_pkg:
  - State encoding (IDLE, BUSY, RELEASE).
  - Requester ID constants (REQ_I=0, REQ_D=1).
  - Default ADDR_W and DATA_W.
- One natural sub-module: cache_mem_arb_pick.
  - Combinational: inputs req_i, req_d, last_grant, FIXED_PRIO; outputs grant_valid and grant_id.
  - The FSM and datapath registers stay in the top.

Test Plan:
- Reset mid-operation: proc_reset_n low for 1 cycle while BUSY with mem_read=1 → mem_read, mem_write and both ready outputs go to 0 immediately (asynchronous); next I request restarts cleanly.
- Single I read: i_mem_read=1, i_mem_addr=28'h0000010; memory raises mem_ready 3 cycles later with mem_rdata=128'h...0004_0005_0006_0007 →
  - mem_read=1 and mem_addr=28'h10 one cycle after the request.
  - i_mem_ready pulses exactly 1 cycle with that data.
  - d_mem_ready stays 0.
- Simultaneous requests after reset: I read 28'h20 and D write 28'h40 with d_mem_wdata=128'hA5 →
  - I is served first (mem_read, addr 28'h20).
  - Then D (mem_write, addr 28'h40, wdata 128'hA5).
  - Each side receives one ready pulse.
- Round-robin fairness (FIXED_PRIO=0): both sides hold requests for 4 transactions, the requester re-asserts after each ready → grant order I,D,I,D; a stale request during RELEASE never produces a grant.
- Fixed priority (FIXED_PRIO=1): both sides requesting for 3 transactions, then D drops → D served 3 times, then I served.
- Conflicting command: D asserts d_mem_read=1 and d_mem_write=1 with addr 28'h5 → mem_write=1, mem_read=0, mem_addr=28'h5; mem_ready arriving in IDLE beforehand is ignored (no ready pulse).
